// File: rtl/alu_pkg.sv
// Shared ALU control encodings for the MIPS datapath.
// Codes not listed here (011, 101) produce a zero result.
package alu_pkg;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_NOR = 3'b100;
endpackage

// File: rtl/alu_1bit.sv
// One bit of the ripple-carry ALU.
// The set output is the raw sum bit; only the MSB slice's copy feeds SLT.
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       binvert,
   input  logic       less,
   input  logic [2:0] op,
   output logic       res,
   output logic       cout,
   output logic       set
);

   logic bb;
   logic sum;

   assign bb   = b ^ binvert;
   assign sum  = a ^ bb ^ cin;
   assign cout = (a & bb) | (a & cin) | (bb & cin);
   assign set  = sum;

   always_comb begin
      res = 1'b0;
      case (op)
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_ADD: res = sum;
         ALU_SUB: res = sum;
         ALU_SLT: res = less;
         ALU_NOR: res = ~(a | b);
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_32bit.sv
// 32-bit MIPS ALU: ripple chain of alu_1bit slices feeding a registered
// result/zero pair, one cycle of latency, async active-low reset.
module alu_32bit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             zero,
   output logic [WIDTH-1:0] result,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   input  logic [2:0]       op
);

   logic [WIDTH-1:0] res_p0;
   logic             less_p0;

   // Carry signals live inside each generate iteration so the chain is a set
   // of distinct nets rather than one self-referencing vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic cin_b;
      logic cout_b;
      logic res_b;
      logic set_b;
      logic less_b;

      if (i == 0) begin : g_lsb
         assign cin_b  = op[2];
         assign less_b = less_p0;
      end else begin : g_upper
         assign cin_b  = g_bit[i-1].cout_b;
         assign less_b = 1'b0;
      end

      alu_1bit u_slice (
         .a       (first[i]),
         .b       (second[i]),
         .cin     (cin_b),
         .binvert (op[2]),
         .less    (less_b),
         .op      (op),
         .res     (res_b),
         .cout    (cout_b),
         .set     (set_b)
      );

      assign res_p0[i] = res_b;
   end

   // Signed less-than: sign of the difference corrected by overflow.
   assign less_p0 = g_bit[WIDTH-1].set_b ^
                    (g_bit[WIDTH-1].cin_b ^ g_bit[WIDTH-1].cout_b);

   // ---- p0 -> output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         zero   <= 1'b1;
      end else begin
         result <= res_p0;
         zero   <= (res_p0 == '0);
      end
   end

endmodule

// File: tb/tb_alu_32bit.sv
// Bench for alu_32bit: directed vector table, reset/hold sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_alu_32bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        zero;
   logic [31:0] result;
   logic [31:0] first = '0;
   logic [31:0] second = '0;
   logic [2:0]  op = 3'b000;

   int checks = 0;
   int errors = 0;

   alu_32bit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .zero   (zero),
      .result (result),
      .first  (first),
      .second (second),
      .op     (op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] o);
      case (o)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b100:  return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
      @(negedge clk);
      first  = a;
      second = b;
      op     = o;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0002, 32'h0000_0001, 3'b110, 32'h0000_0001, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0};
      vecs[4]  = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b1};
      vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b0};
      vecs[6]  = '{32'h0F0F_0000, 32'h0000_F0F0, 3'b001, 32'h0F0F_F0F0, 1'b0};
      vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 3'b100, 32'hFFFF_FFFF, 1'b0};
      vecs[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 32'h0000_0000, 1'b1};
      vecs[9]  = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 32'h0000_0000, 1'b1};
      vecs[10] = '{32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0};
      vecs[11] = '{32'h0000_0005, 32'h0000_0005, 3'b110, 32'h0000_0000, 1'b1};
      vecs[12] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0};
      vecs[13] = '{32'h0000_0005, 32'h0000_0005, 3'b111, 32'h0000_0000, 1'b1};
      vecs[14] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b100, 32'h0000_0000, 1'b1};

      // Reset state, asserted between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check32("reset_result", result, 32'h0);
      check1("reset_zero", zero, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, one per cycle back to back.
      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].op);
         check32($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
         check1($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
      end

      // Inputs changed mid-cycle must not disturb the registered output.
      apply(32'h0000_0003, 32'h0000_0004, 3'b010);
      #2;
      first = 32'h1111_1111; second = 32'h2222_2222; op = 3'b001;
      #1;
      check32("hold_result", result, 32'h0000_0007);
      check1("hold_zero", zero, 1'b0);
      @(posedge clk);
      #1;
      check32("hold_next_result", result, 32'h3333_3333);

      // Async reset mid-stream, held across an edge, then released.
      apply(32'h0000_00F0, 32'h0000_000F, 3'b001);
      check32("pre_reset_result", result, 32'h0000_00FF);
      #2 rst_n = 1'b0;
      #1;
      check32("midreset_result", result, 32'h0);
      check1("midreset_zero", zero, 1'b1);
      @(posedge clk);
      #1;
      check32("held_reset_result", result, 32'h0);
      check1("held_reset_zero", zero, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      apply(32'd5, 32'd7, 3'b010);
      check32("post_reset_add", result, 32'd12);
      check1("post_reset_zero", zero, 1'b0);

      // Randomized operations against the reference model.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, b, exp;
         logic [2:0]  o;
         a = $urandom();
         b = $urandom();
         o = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: a = 32'h8000_0000;
            1: b = 32'h7FFF_FFFF;
            2: b = a;
            default: ;
         endcase
         exp = ref_alu(a, b, o);
         apply(a, b, o);
         check32($sformatf("rand%0d_op%0b_result", n, o), result, exp);
         check1($sformatf("rand%0d_op%0b_zero", n, o), zero, exp == 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
